// File: rtl/tick_gen_multi.sv
// Multi-channel tick / slow-clock generator: each channel strobes `tick` every N clk_in cycles.
// Optional square-wave output on clk_out is compiled in with `define TICKGEN_SQUARE_EN.
module tick_gen_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 21
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH*CNT_W-1:0]   div_val,
    input  logic                      sync_clr,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] act_div_q, act_div_d;
        logic             tick_q, tick_d;
        logic [CNT_W-1:0] div_i;
        logic             wrap;
        logic             load;

        assign div_i = div_val[i*CNT_W +: CNT_W];
        // act_div is never 0 in RUN, so the subtraction cannot underflow there.
        assign wrap  = (cnt_q == act_div_q - ONE);
        // IDLE behaviour, forced on every channel by sync_clr.
        assign load  = sync_clr || (state_q == IDLE);

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            act_div_d = act_div_q;
            tick_d    = 1'b0;
            if (load) begin
                act_div_d = div_i;
                cnt_d     = '0;
                state_d   = (en[i] && (div_i != '0)) ? RUN : IDLE;
            end else if (!en[i]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (wrap) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                act_div_d = div_i;
                if (div_i == '0) begin
                    state_d = IDLE;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                act_div_q <= '0;
                tick_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                act_div_q <= act_div_d;
                tick_q    <= tick_d;
            end
        end

        assign tick[i]    = tick_q;
        assign running[i] = (state_q == RUN);

`ifdef TICKGEN_SQUARE_EN
        logic clk_out_q, clk_out_d;

        // High while the next count sits in the first floor(N/2) slots of the period.
        always_comb begin
            clk_out_d = 1'b0;
            if (!load && en[i]) begin
                clk_out_d = (cnt_d < (act_div_d >> 1));
            end
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                clk_out_q <= 1'b0;
            end else begin
                clk_out_q <= clk_out_d;
            end
        end

        assign clk_out[i] = clk_out_q;
`else
        assign clk_out[i] = 1'b0;
`endif
    end

endmodule
